// File: rtl/usi_bus_pkg.sv
// Shared definitions for the Usi register bus: command codes, address field
// positions and the slave responder state encoding.
package usi_bus_pkg;

    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_WR   = 2'd1,
        CMD_RD   = 2'd2,
        CMD_WRRD = 2'd3
    } usi_cmd_e;

    localparam int unsigned CMD_MSB = 31;
    localparam int unsigned CMD_LSB = 30;
    localparam int unsigned BLK_MSB = 15;
    localparam int unsigned BLK_LSB = 8;
    localparam int unsigned OFS_MSB = 7;
    localparam int unsigned OFS_LSB = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        READ    = 2'd2,
        RELEASE = 2'd3
    } usi_state_e;

    function automatic usi_cmd_e usi_get_cmd(input logic [1:0] field);
        return usi_cmd_e'(field);
    endfunction

endpackage

// File: rtl/usi_slave_responder.sv
// Slave endpoint of the Usi register bus. Decodes commands aimed at this
// block, turns writes into a one-cycle local CSR strobe and returns local
// CSR read data after a fixed wait.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | Vd high, watching for a hit on the command-enable level
// WRITE   | strobe was issued last cycle; drop it and raise Vd
// READ    | counting down the CSR read latency, then capture read data
// RELEASE | command done; wait for the master to clear WCke
module usi_slave_responder
    import usi_bus_pkg::*;
#(
    parameter logic [7:0]  pBlockAdrs = 8'h00,
    parameter int unsigned pRdLatency = 1
) (
    input  logic        iSysClk,
    input  logic        iSysRst,
    input  logic [31:0] iSUsiWd,
    input  logic [31:0] iSUsiAdrs,
    input  logic        iSUsiWCke,
    output logic [31:0] oSUsiRd,
    output logic        oSUsiVd,
    output logic        oCmdErr,
    output logic [31:0] oCsrWd,
    output logic [7:0]  oCsrAdrs,
    output logic        oCsrCke,
    input  logic [31:0] iCsrRd
);

    usi_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rd_q, rd_d;
    logic        vd_q, vd_d;
    logic        err_q, err_d;
    logic [31:0] wd_q, wd_d;
    logic [7:0]  adrs_q, adrs_d;
    logic        cke_q, cke_d;

    logic        hit;
    usi_cmd_e    cmd;

    // Address bits between the command and block fields carry no meaning here.
    logic unused_adrs;
    assign unused_adrs = ^iSUsiAdrs[29:16];

    assign hit = iSUsiWCke && (iSUsiAdrs[BLK_MSB:BLK_LSB] == pBlockAdrs);
    assign cmd = usi_get_cmd(iSUsiAdrs[CMD_MSB:CMD_LSB]);

    // Next-state and registered-output logic; the strobe defaults low so it
    // can only ever last the single cycle spent entering WRITE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        vd_d    = vd_q;
        err_d   = err_q;
        wd_d    = wd_q;
        adrs_d  = adrs_q;
        cke_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (hit) begin
                    case (cmd)
                        CMD_WR: begin
                            wd_d    = iSUsiWd;
                            adrs_d  = iSUsiAdrs[OFS_MSB:OFS_LSB];
                            cke_d   = 1'b1;
                            vd_d    = 1'b0;
                            state_d = WRITE;
                        end
                        CMD_RD: begin
                            adrs_d  = iSUsiAdrs[OFS_MSB:OFS_LSB];
                            cnt_d   = 4'(pRdLatency);
                            vd_d    = 1'b0;
                            state_d = READ;
                        end
                        CMD_WRRD: begin
                            err_d   = 1'b1;
                            state_d = RELEASE;
                        end
                        default: begin
                            state_d = IDLE;
                        end
                    endcase
                end
            end
            WRITE: begin
                vd_d    = 1'b1;
                state_d = RELEASE;
            end
            READ: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rd_d    = iCsrRd;
                    vd_d    = 1'b1;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (!iSUsiWCke) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge iSysClk) begin
        if (!iSysRst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rd_q    <= 32'd0;
            vd_q    <= 1'b1;
            err_q   <= 1'b0;
            wd_q    <= 32'd0;
            adrs_q  <= 8'd0;
            cke_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            vd_q    <= vd_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
            adrs_q  <= adrs_d;
            cke_q   <= cke_d;
        end
    end

    assign oSUsiRd  = rd_q;
    assign oSUsiVd  = vd_q;
    assign oCmdErr  = err_q;
    assign oCsrWd   = wd_q;
    assign oCsrAdrs = adrs_q;
    assign oCsrCke  = cke_q;

endmodule

// File: tb/tb_usi_slave_responder.sv
// Bench for usi_slave_responder: two instances (read latency 1 and 4) share
// the bus inputs, each with its own local CSR model, and are compared with a
// command-level reference model.
module tb_usi_slave_responder;

    localparam logic [7:0] BLK = 8'h12;
    localparam int WIN = 8;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        csr_clr;
    logic [31:0] usi_wd;
    logic [31:0] usi_adrs;
    logic        usi_wcke;

    logic [31:0] s_rd   [2];
    logic        s_vd   [2];
    logic        s_err  [2];
    logic [31:0] s_wd   [2];
    logic [7:0]  s_adrs [2];
    logic        s_cke  [2];
    logic [31:0] csr_rd [2];

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [logic [7:0]];
    logic [31:0] model_rd;
    logic        model_err;

    always #5 clk = ~clk;

    usi_slave_responder #(.pBlockAdrs(BLK), .pRdLatency(1)) dut_l1 (
        .iSysClk(clk), .iSysRst(rst_b), .iSUsiWd(usi_wd), .iSUsiAdrs(usi_adrs),
        .iSUsiWCke(usi_wcke), .oSUsiRd(s_rd[0]), .oSUsiVd(s_vd[0]),
        .oCmdErr(s_err[0]), .oCsrWd(s_wd[0]), .oCsrAdrs(s_adrs[0]),
        .oCsrCke(s_cke[0]), .iCsrRd(csr_rd[0])
    );

    usi_slave_responder #(.pBlockAdrs(BLK), .pRdLatency(4)) dut_l4 (
        .iSysClk(clk), .iSysRst(rst_b), .iSUsiWd(usi_wd), .iSUsiAdrs(usi_adrs),
        .iSUsiWCke(usi_wcke), .oSUsiRd(s_rd[1]), .oSUsiVd(s_vd[1]),
        .oCmdErr(s_err[1]), .oCsrWd(s_wd[1]), .oCsrAdrs(s_adrs[1]),
        .oCsrCke(s_cke[1]), .iCsrRd(csr_rd[1])
    );

    // Local CSR models: storage plus an address pipeline so read data only
    // becomes correct exactly the configured latency after the offset moves.
    logic [31:0]  csr_mem    [2][256];
    logic [255:0] csr_wr_vld [2];
    logic [7:0]   pipe       [2][4];
    logic [7:0]   rd_a0, rd_a1;

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            pipe[d][0] <= s_adrs[d];
            for (int k = 1; k < 4; k++) pipe[d][k] <= pipe[d][k-1];
            if (csr_clr) begin
                csr_wr_vld[d] <= '0;
            end else if (s_cke[d]) begin
                csr_mem[d][s_adrs[d]]    <= s_wd[d];
                csr_wr_vld[d][s_adrs[d]] <= 1'b1;
            end
        end
    end

    assign rd_a0 = pipe[0][0];
    assign rd_a1 = pipe[1][3];
    assign csr_rd[0] = csr_wr_vld[0][rd_a0] ? csr_mem[0][rd_a0] : {24'h0, rd_a0 ^ 8'hAD};
    assign csr_rd[1] = csr_wr_vld[1][rd_a1] ? csr_mem[1][rd_a1] : {24'h0, rd_a1 ^ 8'hAD};

    function automatic logic [31:0] ref_read(input logic [7:0] off);
        if (ref_mem.exists(off)) return ref_mem[off];
        return {24'h0, off ^ 8'hAD};
    endfunction

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d: observed=%h expected=%h", tag, d, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, " rd"},   d, s_rd[d],          32'h0);
            chk({tag, " vd"},   d, 32'(s_vd[d]),     32'h1);
            chk({tag, " err"},  d, 32'(s_err[d]),    32'h0);
            chk({tag, " wd"},   d, s_wd[d],          32'h0);
            chk({tag, " adrs"}, d, 32'(s_adrs[d]),   32'h0);
            chk({tag, " cke"},  d, 32'(s_cke[d]),    32'h0);
        end
    endtask

    // Issue one command, hold WCke for a fixed window, drop it for one cycle,
    // and compare per-cycle Vd/strobe traces and final state with the model.
    task automatic do_cmd(input logic [31:0] a, input logic [31:0] w, input string tag);
        logic        hit;
        logic [1:0]  cmd;
        logic [7:0]  off;
        logic [31:0] exp_read;
        logic [7:0]  exp_vd;
        logic [31:0] exp_rd_end;
        int          lat;
        int          exp_low;
        logic [7:0]  vd_tr  [2];
        logic [7:0]  cke_tr [2];
        logic [31:0] rd_at  [2][WIN];
        logic [7:0]  cap_a  [2];
        logic [31:0] cap_w  [2];

        hit      = (a[15:8] == BLK);
        cmd      = a[31:30];
        off      = a[7:0];
        exp_read = ref_read(off);
        for (int d = 0; d < 2; d++) begin
            vd_tr[d] = '0; cke_tr[d] = '0; cap_a[d] = '0; cap_w[d] = '0;
        end

        usi_adrs = a;
        usi_wd   = w;
        usi_wcke = 1'b1;
        for (int i = 0; i < WIN; i++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                vd_tr[d][i]  = s_vd[d];
                cke_tr[d][i] = s_cke[d];
                rd_at[d][i]  = s_rd[d];
                if (s_cke[d]) begin
                    cap_a[d] = s_adrs[d];
                    cap_w[d] = s_wd[d];
                end
            end
            if (i == 0 && hit && cmd != 2'd0) begin
                usi_adrs = $urandom;
                usi_wd   = $urandom;
            end
        end
        usi_wcke = 1'b0;
        @(negedge clk);

        for (int d = 0; d < 2; d++) begin
            lat     = (d == 0) ? 1 : 4;
            exp_low = (hit && cmd == 2'd1) ? 1 : (hit && cmd == 2'd2) ? lat + 1 : 0;
            exp_vd  = 8'(8'hFF << exp_low);
            chk({tag, " vd_trace"},  d, 32'(vd_tr[d]),  32'(exp_vd));
            chk({tag, " cke_trace"}, d, 32'(cke_tr[d]), (hit && cmd == 2'd1) ? 32'h1 : 32'h0);
            if (hit && cmd == 2'd1) begin
                chk({tag, " csr_adrs"}, d, 32'(cap_a[d]), 32'(off));
                chk({tag, " csr_wd"},   d, cap_w[d],      w);
            end
            if (hit && cmd == 2'd2) begin
                chk({tag, " rd_pre_capture"}, d, rd_at[d][lat],     model_rd);
                chk({tag, " rd_capture"},     d, rd_at[d][lat + 1], exp_read);
            end
            exp_rd_end = (hit && cmd == 2'd2) ? exp_read : model_rd;
            chk({tag, " rd_end"},  d, s_rd[d],        exp_rd_end);
            chk({tag, " err"},     d, 32'(s_err[d]),  32'(model_err | (hit && cmd == 2'd3)));
            chk({tag, " vd_end"},  d, 32'(s_vd[d]),   32'h1);
        end

        if (hit && cmd == 2'd1) ref_mem[off] = w;
        if (hit && cmd == 2'd2) model_rd = exp_read;
        if (hit && cmd == 2'd3) model_err = 1'b1;
    endtask

    initial begin
        logic [7:0]  rblk;
        logic [1:0]  rcmd;
        logic [7:0]  roff;
        logic [31:0] rmid;

        model_rd  = 32'h0;
        model_err = 1'b0;
        rst_b     = 1'b0;
        csr_clr   = 1'b1;
        usi_wd    = 32'h0;
        usi_adrs  = 32'h0;
        usi_wcke  = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst_b   = 1'b1;
        csr_clr = 1'b0;
        @(negedge clk);

        do_cmd(32'h4000_1204, 32'hDEAD_BEEF, "write");
        do_cmd(32'h8000_1208, 32'h1111_1111, "read_a5");
        do_cmd(32'h4000_3404, 32'h2222_2222, "miss");
        do_cmd(32'h0000_1204, 32'h3333_3333, "cmd0");
        do_cmd(32'hC000_1200, 32'h4444_4444, "error");
        do_cmd(32'h4000_1210, 32'hCAFE_F00D, "write_after_err");
        do_cmd(32'h8000_1204, 32'h0, "read_back");
        do_cmd(32'h8000_1210, 32'h0, "read_back2");

        // Reset two cycles into a read aborts it without any capture.
        usi_adrs = 32'h8000_1208;
        usi_wcke = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_rst vd_busy", 0, 32'(s_vd[0]), 32'h0);
        chk("mid_rst vd_busy", 1, 32'(s_vd[1]), 32'h0);
        rst_b    = 1'b0;
        usi_wcke = 1'b0;
        @(negedge clk);
        chk_reset("mid_rst");
        rst_b     = 1'b1;
        usi_adrs  = 32'h0;
        model_rd  = 32'h0;
        model_err = 1'b0;
        @(negedge clk);
        do_cmd(32'h8000_1208, 32'h0, "read_after_rst");

        for (int n = 0; n < 40; n++) begin
            rblk = ($urandom_range(0, 3) == 0) ? 8'($urandom) : BLK;
            rcmd = 2'($urandom_range(0, 3));
            roff = 8'($urandom_range(0, 9));
            rmid = $urandom;
            do_cmd({rcmd, rmid[13:0], rblk, roff}, $urandom, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
